// File: rtl/uart_fifo_transmitter_if.sv
// Byte handshake between the CPU IO logic (master) and the UART transmitter (slave).
interface uart_fifo_transmitter_if;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;

  modport master (output DataIn, output DataInValid, input DataInReady);
  modport slave  (input DataIn, input DataInValid, output DataInReady);
endinterface

// File: rtl/uart_fifo_transmitter.sv
// UART transmit path: small byte FIFO feeding an 8N1 serialiser, LSB first.
module uart_fifo_transmitter #(
  parameter int unsigned ClockFreq  = 50_000_000,
  parameter int unsigned BaudRate   = 115_200,
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned CountWidth = 3
) (
  input  logic                      Clock,
  input  logic                      Reset,
  uart_fifo_transmitter_if.slave    Bus,
  output logic                      SOut,
  output logic                      Busy,
  output logic [CountWidth-1:0]     Count
);

  localparam int unsigned SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int unsigned BaudWidth      = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam int unsigned PtrWidth       = $clog2(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_d;
  logic [BaudWidth-1:0]  baud_cnt, baud_cnt_d;
  logic [2:0]            bit_idx, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  sout_q, sout_d;
  logic                  baud_last;
  logic                  push, pop;

  logic [7:0]            fifo_mem [FifoDepth];
  logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
  logic [CountWidth-1:0] count_q;

  // Ready depends only on the registered fill level, never on DataInValid.
  assign Bus.DataInReady = (count_q != CountWidth'(FifoDepth));
  assign push            = Bus.DataInValid && Bus.DataInReady;
  assign baud_last       = (baud_cnt == BaudWidth'(SymbolEdgeTime - 1));
  assign Count           = count_q;
  assign Busy            = (state != IDLE) || (count_q != '0);
  assign SOut            = sout_q;

  // Next-state and datapath decode; SOut is registered from the current state.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift_q;
    sout_d     = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shift_d    = fifo_mem[rd_ptr];
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        sout_d = 1'b0;
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + BaudWidth'(1);
        end
      end
      DATA: begin
        sout_d = shift_q[0];
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end else begin
          baud_cnt_d = baud_cnt + BaudWidth'(1);
        end
      end
      STOP: begin
        sout_d = 1'b1;
        if (baud_last) begin
          baud_cnt_d = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + BaudWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and serialiser registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      sout_q   <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift_q  <= shift_d;
      sout_q   <= sout_d;
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CountWidth'(1);
        2'b01:   count_q <= count_q - CountWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= Bus.DataIn;
  end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Directed bench for uart_fifo_transmitter: single-frame vector table plus multi-byte sequences.
module tb_uart_fifo_transmitter;

  logic       Clock;
  logic       Reset;
  logic       SOut;
  logic       Busy;
  logic [2:0] Count;

  uart_fifo_transmitter_if bus ();

  uart_fifo_transmitter #(
    .ClockFreq (1000),
    .BaudRate  (100),
    .FifoDepth (4),
    .CountWidth(3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Bus  (bus),
    .SOut (SOut),
    .Busy (Busy),
    .Count(Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge Clock) cyc++;

  // Reference UART receiver, sampling mid-symbol on the falling clock edge.
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         rx_frame_err = 0;
  int         rx_cnt = 0;
  bit         rx_active = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  int         max_count = 0;

  always @(negedge Clock) begin
    if (int'(Count) > max_count) max_count = int'(Count);
    if (Reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (SOut === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_start_q.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 5) begin
        if (SOut !== 1'b0) rx_frame_err++;
      end else if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5) begin
        rx_sh = {SOut, rx_sh[7:1]};
      end else if (rx_cnt == 95) begin
        if (SOut !== 1'b1) rx_frame_err++;
        rx_q.push_back(rx_sh);
        rx_active = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present a byte, wait (bounded) for ready, and return just after the accepting edge.
  task automatic push_byte(input logic [7:0] b, output int waited);
    waited = 0;
    bus.DataIn      = b;
    bus.DataInValid = 1'b1;
    while (!bus.DataInReady && waited < 500) begin
      step();
      waited++;
    end
    step();
    bus.DataInValid = 1'b0;
    bus.DataIn      = ~b;
  endtask

  task automatic wait_rx(input int n, input int limit, input string name);
    int w = 0;
    while (rx_q.size() < n && w < limit) begin
      step();
      w++;
    end
    check({name, "_rx_timeout"}, 32'(rx_q.size()), 32'(n));
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] exp_bytes[$];
  logic [7:0] wrap_data[10];

  initial begin
    int   w;
    logic ok;
    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h81, frame: 10'h302};
    vecs[2] = '{data: 8'h3C, frame: 10'h278};
    vecs[3] = '{data: 8'hFF, frame: 10'h3FE};

    Reset           = 1'b1;
    bus.DataIn      = 8'h00;
    bus.DataInValid = 1'b0;
    step();
    step();
    Reset = 1'b0;
    check("rst_sout",  32'(SOut), 32'd1);
    check("rst_ready", 32'(bus.DataInReady), 32'd1);
    check("rst_busy",  32'(Busy), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    step();
    check("rst_idle_sout", 32'(SOut), 32'd1);

    // Single frames: exact latency, every symbol cycle, and Busy fall time.
    for (int v = 0; v < 4; v++) begin
      push_byte(vecs[v].data, w);
      check($sformatf("v%0d_count_after_push", v), 32'(Count), 32'd1);
      step();
      check($sformatf("v%0d_sout_pop_cycle", v), 32'(SOut), 32'd1);
      check($sformatf("v%0d_count_popped", v), 32'(Count), 32'd0);
      check($sformatf("v%0d_busy", v), 32'(Busy), 32'd1);
      for (int k = 0; k < 10; k++) begin
        ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
          step();
          if (SOut !== vecs[v].frame[k]) ok = 1'b0;
          if (k == 9 && j == 8) check($sformatf("v%0d_busy_last_stop", v), 32'(Busy), 32'd1);
        end
        check($sformatf("v%0d_sym%0d", v, k), 32'(ok), 32'd1);
      end
      check($sformatf("v%0d_busy_done", v), 32'(Busy), 32'd0);
      step();
      check($sformatf("v%0d_sout_idle", v), 32'(SOut), 32'd1);
    end

    // Back-to-back bytes must produce contiguous frames.
    rx_q.delete();
    rx_start_q.delete();
    rx_frame_err = 0;
    push_byte(8'h00, w);
    push_byte(8'hFF, w);
    push_byte(8'h3C, w);
    wait_rx(3, 400, "b2b");
    if (rx_q.size() == 3) begin
      check("b2b_byte0", 32'(rx_q[0]), 32'h00);
      check("b2b_byte1", 32'(rx_q[1]), 32'hFF);
      check("b2b_byte2", 32'(rx_q[2]), 32'h3C);
      check("b2b_gap01", 32'(rx_start_q[1] - rx_start_q[0]), 32'd100);
      check("b2b_gap12", 32'(rx_start_q[2] - rx_start_q[1]), 32'd100);
    end
    check("b2b_frame_err", 32'(rx_frame_err), 32'd0);
    repeat (5) step();

    // Fill to full, hold a sixth byte until the first pop frees a slot.
    rx_q.delete();
    rx_frame_err = 0;
    max_count    = 0;
    exp_bytes    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 5; i++) push_byte(exp_bytes[i], w);
    check("full_count", 32'(Count), 32'd4);
    check("full_ready", 32'(bus.DataInReady), 32'd0);
    bus.DataIn      = 8'h66;
    bus.DataInValid = 1'b1;
    w = 0;
    while (!bus.DataInReady && w < 200) begin
      step();
      w++;
    end
    check("full_wait_cycles", 32'(w), 32'd97);
    check("full_count_after_pop", 32'(Count), 32'd3);
    step();
    bus.DataInValid = 1'b0;
    bus.DataIn      = 8'h99;
    check("full_count_refill", 32'(Count), 32'd4);
    wait_rx(6, 800, "full");
    for (int i = 0; i < 6; i++)
      if (i < rx_q.size()) check($sformatf("full_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
    check("full_frame_err", 32'(rx_frame_err), 32'd0);
    check("full_max_count", 32'(max_count), 32'd4);
    repeat (5) step();

    // Reset during data bit 3 aborts the frame and drops buffered bytes.
    push_byte(8'h81, w);
    push_byte(8'h5A, w);
    repeat (44) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid_rst_sout",  32'(SOut), 32'd1);
    check("mid_rst_count", 32'(Count), 32'd0);
    check("mid_rst_busy",  32'(Busy), 32'd0);
    check("mid_rst_ready", 32'(bus.DataInReady), 32'd1);
    repeat (3) step();
    rx_q.delete();
    rx_frame_err = 0;
    push_byte(8'h42, w);
    wait_rx(1, 200, "post_rst");
    if (rx_q.size() >= 1) check("post_rst_byte", 32'(rx_q[0]), 32'h42);
    repeat (20) step();
    check("post_rst_extra", 32'(rx_q.size()), 32'd1);
    check("post_rst_frame_err", 32'(rx_frame_err), 32'd0);

    // Ten bytes with the FIFO held at 1..3 entries; pointers wrap twice.
    rx_q.delete();
    rx_frame_err = 0;
    max_count    = 0;
    for (int i = 0; i < 10; i++) wrap_data[i] = 8'(i * 29 + 7);
    begin
      int i = 0;
      int guard = 0;
      while (i < 10 && guard < 3000) begin
        if (Count < 3'd3) begin
          bus.DataIn      = wrap_data[i];
          bus.DataInValid = 1'b1;
          step();
          bus.DataInValid = 1'b0;
          i++;
        end else begin
          step();
        end
        guard++;
      end
      check("wrap_all_pushed", 32'(i), 32'd10);
    end
    wait_rx(10, 1200, "wrap");
    for (int i = 0; i < 10; i++)
      if (i < rx_q.size()) check($sformatf("wrap_byte%0d", i), 32'(rx_q[i]), 32'(wrap_data[i]));
    check("wrap_max_count", 32'(max_count), 32'd3);
    check("wrap_frame_err", 32'(rx_frame_err), 32'd0);
    repeat (10) step();
    check("wrap_final_busy", 32'(Busy), 32'd0);
    check("wrap_final_count", 32'(Count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_fifo_transmitter.md
Name: uart_fifo_transmitter

Overview:
Serial transmit side of the on-chip UART link. It accepts bytes from the CPU memory-mapped IO logic over a valid/ready handshake and buffers them in a small FIFO. It serialises each byte as an 8N1 frame, LSB first, on the FPGA serial output pin. The CPU's IO interface sees it through DataIn/DataInValid/DataInReady, the same handshake used for the UART transmit path.

Parameters:
ClockFreq, 50_000_000, system clock frequency in Hz
BaudRate, 115_200, serial bit rate; SymbolEdgeTime = ClockFreq/BaudRate (integer divide, 434 at defaults)
FifoDepth, 4, byte buffer entries; must be a power of two, >= 2
CountWidth, 3, width of Count port; must equal log2(FifoDepth)+1

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
DataIn  input  8  byte to transmit
DataInValid  input  1  DataIn holds a byte to enqueue
DataInReady  output  1  FIFO can accept a byte this cycle
SOut  output  1  serial line, idle high, registered
Busy  output  1  frame in progress or FIFO non-empty
Count  output  CountWidth  bytes currently held in FIFO (excludes byte in shift register)

Behaviour:
- Reset: FIFO pointers and Count = 0, FSM = IDLE, SOut = 1, bit counter and baud counter = 0. DataInReady = 1 and Busy = 0 from the first cycle after reset.
- Enqueue: on a rising edge with DataInValid && DataInReady, DataIn is written at the write pointer and the pointer increments modulo FifoDepth.
- DataInReady = (Count != FifoDepth). It is combinational from registered Count only, with no path from DataInValid.
- When full, DataInValid is ignored and no data is overwritten.
- Dequeue: happens only in the FSM (see IDLE and STOP). The read pointer increments modulo FifoDepth.
- Count: same-edge push and pop leave Count unchanged; push alone adds 1; pop alone subtracts 1.
- Pointer wrap-around must be exercised. Count is the sole full/empty indicator.
- FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..SymbolEdgeTime-1 within each bit period.
- IDLE: SOut = 1. If Count != 0, pop the head byte into the 8-bit shift register, clear the baud counter, go to START.
- START: SOut = 0 for exactly SymbolEdgeTime cycles, then go to DATA with bit index 0.
- DATA: SOut = shift[0] for SymbolEdgeTime cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
- STOP: SOut = 1 for SymbolEdgeTime cycles. On the final STOP cycle, if Count != 0, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1, and SOut is 0 from edge N+2. The frame occupies exactly 10*SymbolEdgeTime cycles.
- Busy = (state != IDLE) || (Count != 0), registered-state derived.
- Simultaneous events:
  - Push and pop on the same edge are legal when Count is between 1 and FifoDepth-1.
  - A push into an empty FIFO is not visible to the IDLE pop until the next edge.
  - A pop from a full FIFO raises DataInReady on the following cycle.
- Reset mid-frame: the frame is aborted, SOut returns to 1 after the reset edge, buffered bytes are discarded, and the state is as after reset.
- DataIn is sampled only on the accepting edge; later changes to it have no effect.

Test Plan:
- Use ClockFreq=1000 and BaudRate=100, giving SymbolEdgeTime=10. Reset for 2 cycles -> SOut=1, DataInReady=1, Busy=0, Count=0.
- Push 8'hA5 at edge N -> SOut=0 during cycles N+2..N+11. Data bits 1,0,1,0,0,1,0,1 follow, each held 10 cycles, then stop=1 for 10 cycles. Busy falls after cycle N+101.
- Push 8'h00, 8'hFF, 8'h3C back to back -> three contiguous 100-cycle frames with no idle gap. Decoded bytes are 00, FF, 3C in order.
- Push 5 bytes on consecutive cycles starting with the FSM idle -> the first is popped immediately and the remaining 4 fill the FIFO. Count reaches 4 and DataInReady=0. A 6th byte held valid is not accepted until the first pop from the full FIFO; all 6 bytes are transmitted in order.
- Push 8'h81 and assert Reset during DATA bit 3 -> SOut=1 the cycle after reset, Count=0, Busy=0. A subsequent push of 8'h42 transmits a clean 8'h42 frame.
- Run 10 bytes through the FIFO while holding Count at 1..3 with interleaved push/pop -> pointers wrap at least twice, every byte is received unchanged and in order, and Count never exceeds 4.
